// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker: after a programmed run, scans regfile port A against an expected-value ROM.
// Ports: clock/reset (async active-low); start, run_cycles, stop_on_fail configure a run;
// cpu_readRegA -> regfile_readRegA is muxed with the scan index; data_readRegA is the regfile data;
// ctrl_writeEnable/ctrl_writeReg are monitored for wr_count; exp_addr/exp_data address the ROM;
// test_mode holds the processor; mismatch_* report failures; error_count, done, pass give the verdict.
module regfile_scan_checker #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CYC_W    = 16,
  parameter int ERR_W    = $clog2(NUM_REGS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic              stop_on_fail,
  input  logic [ADDR_W-1:0] cpu_readRegA,
  output logic [ADDR_W-1:0] regfile_readRegA,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              test_mode,
  output logic              mismatch_valid,
  output logic [ADDR_W-1:0] mismatch_reg,
  output logic [DATA_W-1:0] mismatch_exp,
  output logic [DATA_W-1:0] mismatch_act,
  output logic [CYC_W-1:0]  wr_count,
  output logic [ERR_W-1:0]  error_count,
  output logic              done,
  output logic              pass
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]        state;
  logic [CYC_W-1:0]  cnt;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] act_q;
  logic              cmp_v;
  logic              sof_q;
  logic              scan;
  logic              cmp;
  logic              miss;
  logic              accept;
  // The ROM answers one cycle after exp_addr, so regfile data is held in act_q for that cycle.
  always_comb begin
    scan   = state == S_SCAN;
    cmp    = cmp_v && (scan || state == S_DRAIN);
    miss   = cmp && exp_data != act_q;
    accept = start && (state == S_IDLE || state == S_DONE);
  end
  assign regfile_readRegA = scan ? i : cpu_readRegA;
  assign exp_addr         = scan ? i : '0;
  assign test_mode        = scan || state == S_DRAIN;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      i              <= '0;
      idx_q          <= '0;
      act_q          <= '0;
      cmp_v          <= 1'b0;
      sof_q          <= 1'b0;
      wr_count       <= '0;
      error_count    <= '0;
      mismatch_valid <= 1'b0;
      mismatch_reg   <= '0;
      mismatch_exp   <= '0;
      mismatch_act   <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      cmp_v <= scan;
      act_q <= data_readRegA;
      idx_q <= i;
      if (accept) begin
        state          <= run_cycles == '0 ? S_SCAN : S_RUN;
        cnt            <= run_cycles;
        sof_q          <= stop_on_fail;
        i              <= '0;
        wr_count       <= '0;
        error_count    <= '0;
        mismatch_valid <= 1'b0;
        mismatch_reg   <= '0;
        mismatch_exp   <= '0;
        mismatch_act   <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
      end else begin
        mismatch_valid <= miss;
        if (miss) begin
          mismatch_reg <= idx_q;
          mismatch_exp <= exp_data;
          mismatch_act <= act_q;
          if (error_count != '1) error_count <= error_count + 1'b1;
        end
        case (state)
          S_RUN: begin
            cnt <= cnt - 1'b1;
            if (cnt == CYC_W'(1)) state <= S_SCAN;
            if (ctrl_writeEnable && ctrl_writeReg != '0 && wr_count != '1) wr_count <= wr_count + 1'b1;
          end
          S_SCAN: begin
            i <= i + 1'b1;
            if (miss && sof_q) state <= S_DONE;
            else if (i == ADDR_W'(NUM_REGS - 1)) state <= S_DRAIN;
          end
          S_DRAIN: state <= S_DONE;
          // Verdict flags register one cycle into DONE, giving start-to-done of run_cycles + NUM_REGS + 2.
          S_DONE: begin
            done <= 1'b1;
            pass <= error_count == '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb_regfile_scan_checker: directed stimulus, spec-level timing model and per-cycle output checks.
module tb_regfile_scan_checker;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int EW = 6;
  logic          clock = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [CW-1:0] run_cycles = 0;
  logic          stop_on_fail = 0;
  logic [AW-1:0] cpu_readRegA = 0;
  logic [AW-1:0] regfile_readRegA;
  logic [DW-1:0] data_readRegA;
  logic          ctrl_writeEnable = 0;
  logic [AW-1:0] ctrl_writeReg = 0;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data = 0;
  logic          test_mode;
  logic          mismatch_valid;
  logic [AW-1:0] mismatch_reg;
  logic [DW-1:0] mismatch_exp;
  logic [DW-1:0] mismatch_act;
  logic [CW-1:0] wr_count;
  logic [EW-1:0] error_count;
  logic          done;
  logic          pass;
  regfile_scan_checker dut (
    .clock(clock), .reset(reset), .start(start), .run_cycles(run_cycles),
    .stop_on_fail(stop_on_fail), .cpu_readRegA(cpu_readRegA), .regfile_readRegA(regfile_readRegA),
    .data_readRegA(data_readRegA), .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .exp_addr(exp_addr), .exp_data(exp_data), .test_mode(test_mode), .mismatch_valid(mismatch_valid),
    .mismatch_reg(mismatch_reg), .mismatch_exp(mismatch_exp), .mismatch_act(mismatch_act),
    .wr_count(wr_count), .error_count(error_count), .done(done), .pass(pass)
  );
  always #5 clock = ~clock;
  logic [DW-1:0] rf [N];
  logic [DW-1:0] rom [N];
  assign data_readRegA = rf[regfile_readRegA];
  always @(posedge clock) exp_data <= rom[exp_addr];
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  bit m_active = 0;
  bit m_sof = 0;
  int m_start = 0;
  int m_r = 0;
  int m_wr = 0;
  int m_errs[$];
  bit done_prev = 0;
  int done_rise = -1;
  int pq_reg[$];
  int pq_rel[$];
  logic [DW-1:0] pq_exp[$];
  logic [DW-1:0] pq_act[$];
  int rel, k0, tm_end, done_at, ec, pk;
  bit stopped, tm, scanning, pv, dexp;
  always @(negedge clock) begin
    if (m_active && reset) begin
      rel      = cyc - m_start;
      k0       = m_errs.size() > 0 ? m_errs[0] : -1;
      stopped  = m_sof && k0 >= 0;
      tm_end   = stopped ? m_r + k0 + 1 : m_r + N;
      done_at  = stopped ? m_r + k0 + 3 : m_r + N + 2;
      tm       = rel >= m_r && rel <= tm_end;
      scanning = tm && rel <= m_r + N - 1;
      dexp     = rel >= done_at;
      ec = 0;
      pv = 0;
      pk = 0;
      foreach (m_errs[j]) begin
        if (!stopped || j == 0) begin
          if (m_r + m_errs[j] + 2 <= rel) ec++;
          if (m_r + m_errs[j] + 2 == rel) begin
            pv = 1;
            pk = m_errs[j];
          end
        end
      end
      chk("test_mode", test_mode, tm);
      chk("readRegA", regfile_readRegA, scanning ? rel - m_r : cpu_readRegA);
      if (scanning) chk("exp_addr", exp_addr, rel - m_r);
      chk("mismatch_valid", mismatch_valid, pv);
      if (pv) begin
        chk("mismatch_reg", mismatch_reg, pk);
        chk("mismatch_exp", mismatch_exp, rom[pk]);
        chk("mismatch_act", mismatch_act, rf[pk]);
      end
      chk("error_count", error_count, ec);
      chk("done", done, dexp);
      chk("pass", pass, dexp && ec == 0);
      chk("wr_count", wr_count, m_wr);
      if (rel < m_r && ctrl_writeEnable && ctrl_writeReg != 0) m_wr++;
      if (done && !done_prev) done_rise = rel;
      done_prev = done;
      if (mismatch_valid) begin
        pq_reg.push_back(mismatch_reg);
        pq_exp.push_back(mismatch_exp);
        pq_act.push_back(mismatch_act);
        pq_rel.push_back(rel);
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
    cpu_readRegA = AW'($urandom);
  endtask
  task automatic do_start(input int r, input bit sof);
    start = 1;
    run_cycles = CW'(r);
    stop_on_fail = sof;
    tick();
    start = 0;
    m_start = cyc;
    m_r = r;
    m_sof = sof;
    m_wr = 0;
    m_errs.delete();
    for (int k = 0; k < N; k++) if (rf[k] != rom[k]) m_errs.push_back(k);
    pq_reg.delete();
    pq_exp.delete();
    pq_act.delete();
    pq_rel.delete();
    done_prev = done;
    done_rise = -1;
    m_active = 1;
  endtask
  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    repeat (3) tick();
  endtask
  task automatic fill_match();
    for (int k = 0; k < N; k++) begin
      rf[k] = (k * 32'h01010101) ^ 32'hA5;
      rom[k] = rf[k];
    end
  endtask
  task automatic fill_two_bad();
    fill_match();
    rf[3] = 32'd7;
    rom[3] = 32'd9;
    rf[31] = 32'hFFFFFFFF;
    rom[31] = 32'd0;
  endtask
  initial begin
    fill_match();
    repeat (3) tick();
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_test_mode", test_mode, 0);
    chk("rst_mismatch_valid", mismatch_valid, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_exp_addr", exp_addr, 0);
    reset = 1;
    tick();
    fill_two_bad();
    do_start(5, 0);
    ctrl_writeEnable = 1;
    ctrl_writeReg = 5;
    repeat (2) tick();
    cpu_readRegA = 0;
    #2;
    m_active = 0;
    reset = 0;
    #1;
    chk("abort_test_mode", test_mode, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_count", wr_count, 0);
    chk("abort_error_count", error_count, 0);
    chk("abort_mismatch_reg", mismatch_reg, 0);
    chk("abort_readRegA", regfile_readRegA, 0);
    ctrl_writeEnable = 0;
    repeat (2) tick();
    reset = 1;
    tick();
    fill_match();
    do_start(10, 0);
    wait_done(100);
    chk("pass_done_latency", done_rise, 44);
    chk("pass_pass", pass, 1);
    chk("pass_errors", error_count, 0);
    chk("pass_pulses", pq_reg.size(), 0);
    fill_two_bad();
    do_start(3, 0);
    wait_done(100);
    chk("two_pulses", pq_reg.size(), 2);
    if (pq_reg.size() == 2) begin
      chk("two_p0_reg", pq_reg[0], 3);
      chk("two_p0_exp", pq_exp[0], 9);
      chk("two_p0_act", pq_act[0], 7);
      chk("two_p1_reg", pq_reg[1], 31);
      chk("two_p1_exp", pq_exp[1], 0);
      chk("two_p1_act", pq_act[1], 32'hFFFFFFFF);
    end
    chk("two_errors", error_count, 2);
    chk("two_pass", pass, 0);
    do_start(3, 1);
    wait_done(100);
    chk("stop_pulses", pq_reg.size(), 1);
    if (pq_reg.size() == 1) begin
      chk("stop_p0_reg", pq_reg[0], 3);
      chk("stop_done_after_pulse", done_rise - pq_rel[0], 1);
    end
    chk("stop_done_rel", done_rise, 9);
    chk("stop_errors", error_count, 1);
    chk("stop_pass", pass, 0);
    fill_match();
    do_start(8, 0);
    for (int j = 0; j < 8; j++) begin
      ctrl_writeEnable = j != 3 && j != 6;
      ctrl_writeReg = (j == 2 || j == 5) ? 5'd0 : 5'd5;
      start = j == 3;
      tick();
    end
    ctrl_writeEnable = 1;
    ctrl_writeReg = 5'd9;
    repeat (4) tick();
    start = 1;
    tick();
    start = 0;
    ctrl_writeEnable = 0;
    wait_done(100);
    chk("wr_count_final", wr_count, 4);
    chk("wr_done_latency", done_rise, 42);
    chk("wr_pass", pass, 1);
    fill_two_bad();
    do_start(0, 0);
    chk("zero_scan_immediate", test_mode, 1);
    wait_done(100);
    chk("zero_done_latency", done_rise, 34);
    chk("zero_errors", error_count, 2);
    do_start(0, 0);
    chk("restart_cleared_done", done, 0);
    chk("restart_cleared_errors", error_count, 0);
    wait_done(100);
    chk("restart_done_latency", done_rise, 34);
    chk("restart_errors", error_count, 2);
    chk("restart_pulses", pq_reg.size(), 2);
    chk("restart_pass", pass, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
